// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, 32-bit ALU, branch resolution and EX/MEM register.
// Latency: branch_taken/branch_target combinational; EX/MEM outputs one cycle after sampling.
// Backpressure: freeze holds the EX/MEM register and masks branch_taken until released.
//
// Ports:
//   clk, rst (async active-low), freeze (memory-stage stall)
//   val1/val2/reg2/pc/dest/exe_cmd/mem_signal/branch_type/wb_en : ID/EX register outputs
//   fwd_sel1/fwd_sel2/fwd_sel_st : forwarding selects (01 MEM, 10 WB, 00/11 ID/EX value)
//   mem_fwd_data/wb_fwd_data : forwarded results from MEM and WB
//   branch_taken/branch_target : combinational redirect to IF and flush to ID
//   alu_result_out/st_value_out/dest_out/mem_read_out/mem_write_out/wb_en_out : EX/MEM register
module exe_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic [31:0] val1,
   input  logic [31:0] val2,
   input  logic [31:0] reg2,
   input  logic [31:0] pc,
   input  logic [4:0]  dest,
   input  logic [3:0]  exe_cmd,
   input  logic [1:0]  mem_signal,
   input  logic [1:0]  branch_type,
   input  logic        wb_en,
   input  logic [1:0]  fwd_sel1,
   input  logic [1:0]  fwd_sel2,
   input  logic [1:0]  fwd_sel_st,
   input  logic [31:0] mem_fwd_data,
   input  logic [31:0] wb_fwd_data,
   output logic        branch_taken,
   output logic [31:0] branch_target,
   output logic [31:0] alu_result_out,
   output logic [31:0] st_value_out,
   output logic [4:0]  dest_out,
   output logic        mem_read_out,
   output logic        mem_write_out,
   output logic        wb_en_out
);

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_BEZ  = 2'b01,
      BR_BNE  = 2'b10,
      BR_JMP  = 2'b11
   } br_type_e;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_AND = 4'b0100;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_NOR = 4'b0110;
   localparam logic [3:0] ALU_XOR = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRA = 4'b1001;
   localparam logic [3:0] ALU_SRL = 4'b1010;

   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] op_s;
   logic [31:0] alu_res;
   logic [4:0]  shamt;
   logic        br_cond;

   logic [31:0] alu_result_q, alu_result_d;
   logic [31:0] st_value_q,   st_value_d;
   logic [4:0]  dest_q,       dest_d;
   logic        mem_read_q,   mem_read_d;
   logic        mem_write_q,  mem_write_d;
   logic        wb_en_q,      wb_en_d;

   // Select 11 is unused by the hazard unit and falls back to the ID/EX value.
   function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                           input logic [31:0] idex_val,
                                           input logic [31:0] mem_val,
                                           input logic [31:0] wb_val);
      case (sel)
         2'b01:   return mem_val;
         2'b10:   return wb_val;
         default: return idex_val;
      endcase
   endfunction

   always_comb begin
      op_a = fwd_mux(fwd_sel1,   val1, mem_fwd_data, wb_fwd_data);
      op_b = fwd_mux(fwd_sel2,   val2, mem_fwd_data, wb_fwd_data);
      op_s = fwd_mux(fwd_sel_st, reg2, mem_fwd_data, wb_fwd_data);
   end

   // Only the low five bits of b count as a shift amount, so b=32 shifts by 0.
   assign shamt = op_b[4:0];

   always_comb begin
      alu_res = 32'd0;
      case (exe_cmd)
         ALU_ADD: alu_res = op_a + op_b;
         ALU_SUB: alu_res = op_a - op_b;
         ALU_AND: alu_res = op_a & op_b;
         ALU_OR:  alu_res = op_a | op_b;
         ALU_NOR: alu_res = ~(op_a | op_b);
         ALU_XOR: alu_res = op_a ^ op_b;
         ALU_SLL: alu_res = op_a << shamt;
         ALU_SRA: alu_res = $unsigned($signed(op_a) >>> shamt);
         ALU_SRL: alu_res = op_a >> shamt;
         default: alu_res = 32'd0;
      endcase
   end

   always_comb begin
      br_cond = 1'b0;
      case (br_type_e'(branch_type))
         BR_BEZ:  br_cond = (op_a == 32'd0);
         BR_BNE:  br_cond = (op_a != op_s);
         BR_JMP:  br_cond = 1'b1;
         default: br_cond = 1'b0;
      endcase
   end

   // A frozen branch stays in ID/EX upstream, so masking here delays the
   // redirect until the stall clears rather than losing it.
   assign branch_taken  = br_cond & ~freeze & rst;
   // Target uses the raw immediate: branch offsets are never forwarded.
   assign branch_target = pc + {val2[29:0], 2'b00};

   always_comb begin
      alu_result_d = alu_result_q;
      st_value_d   = st_value_q;
      dest_d       = dest_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      wb_en_d      = wb_en_q;
      if (!freeze) begin
         alu_result_d = alu_res;
         st_value_d   = op_s;
         dest_d       = dest;
         mem_read_d   = mem_signal[1];
         mem_write_d  = mem_signal[0];
         wb_en_d      = wb_en;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_result_q <= 32'd0;
         st_value_q   <= 32'd0;
         dest_q       <= 5'd0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         wb_en_q      <= 1'b0;
      end else begin
         alu_result_q <= alu_result_d;
         st_value_q   <= st_value_d;
         dest_q       <= dest_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         wb_en_q      <= wb_en_d;
      end
   end

   assign alu_result_out = alu_result_q;
   assign st_value_out   = st_value_q;
   assign dest_out       = dest_q;
   assign mem_read_out   = mem_read_q;
   assign mem_write_out  = mem_write_q;
   assign wb_en_out      = wb_en_q;

endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage: directed scenarios plus randomized traffic against a behavioural model.
// Latency: checks combinational branch outputs mid-cycle and registered outputs 1 time unit after posedge.
// Backpressure: freeze is exercised both directed and at random.
module tb_exe_stage;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic [31:0] val1, val2, reg2, pc;
   logic [4:0]  dest;
   logic [3:0]  exe_cmd;
   logic [1:0]  mem_signal, branch_type;
   logic        wb_en;
   logic [1:0]  fwd_sel1, fwd_sel2, fwd_sel_st;
   logic [31:0] mem_fwd_data, wb_fwd_data;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] alu_result_out, st_value_out;
   logic [4:0]  dest_out;
   logic        mem_read_out, mem_write_out, wb_en_out;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: what the EX/MEM register should be holding.
   logic [31:0] exp_alu, exp_st;
   logic [4:0]  exp_dest;
   logic        exp_rd, exp_wr, exp_wb;

   exe_stage dut (
      .clk           (clk),
      .rst           (rst),
      .freeze        (freeze),
      .val1          (val1),
      .val2          (val2),
      .reg2          (reg2),
      .pc            (pc),
      .dest          (dest),
      .exe_cmd       (exe_cmd),
      .mem_signal    (mem_signal),
      .branch_type   (branch_type),
      .wb_en         (wb_en),
      .fwd_sel1      (fwd_sel1),
      .fwd_sel2      (fwd_sel2),
      .fwd_sel_st    (fwd_sel_st),
      .mem_fwd_data  (mem_fwd_data),
      .wb_fwd_data   (wb_fwd_data),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .alu_result_out(alu_result_out),
      .st_value_out  (st_value_out),
      .dest_out      (dest_out),
      .mem_read_out  (mem_read_out),
      .mem_write_out (mem_write_out),
      .wb_en_out     (wb_en_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] v);
      if (sel == 2'd1) return mem_fwd_data;
      if (sel == 2'd2) return wb_fwd_data;
      return v;
   endfunction

   function automatic logic [31:0] alu_model(input logic [3:0] cmd, input logic [31:0] a,
                                             input logic [31:0] b);
      int sh;
      sh = b % 32;
      case (cmd)
         4'd0:  return a + b;
         4'd2:  return a - b;
         4'd4:  return a & b;
         4'd5:  return a | b;
         4'd6:  return ~(a | b);
         4'd7:  return a ^ b;
         4'd8:  return a << sh;
         4'd9:  return $unsigned($signed(a) >>> sh);
         4'd10: return a >> sh;
         default: return 32'd0;
      endcase
   endfunction

   task automatic clear_inputs();
      freeze = 0; val1 = 0; val2 = 0; reg2 = 0; pc = 0; dest = 0;
      exe_cmd = 4'hF; mem_signal = 0; branch_type = 0; wb_en = 0;
      fwd_sel1 = 0; fwd_sel2 = 0; fwd_sel_st = 0; mem_fwd_data = 0; wb_fwd_data = 0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".alu"},  alu_result_out, exp_alu);
      check({tag, ".st"},   st_value_out, exp_st);
      check({tag, ".dest"}, {27'd0, dest_out}, {27'd0, exp_dest});
      check({tag, ".rd"},   {31'd0, mem_read_out}, {31'd0, exp_rd});
      check({tag, ".wr"},   {31'd0, mem_write_out}, {31'd0, exp_wr});
      check({tag, ".wb"},   {31'd0, wb_en_out}, {31'd0, exp_wb});
   endtask

   // Called just after a negedge with inputs already driven: checks the
   // combinational branch outputs, advances one clock, checks EX/MEM.
   task automatic step(input string tag);
      logic [31:0] a, b, s;
      logic        cond;
      #1;
      a = pick(fwd_sel1, val1);
      b = pick(fwd_sel2, val2);
      s = pick(fwd_sel_st, reg2);
      case (branch_type)
         2'd1:    cond = (a == 0);
         2'd2:    cond = (a != s);
         2'd3:    cond = 1'b1;
         default: cond = 1'b0;
      endcase
      check({tag, ".taken"},  {31'd0, branch_taken}, {31'd0, cond && !freeze && rst});
      check({tag, ".target"}, branch_target, pc + val2 * 32'd4);
      if (!freeze && rst) begin
         exp_alu = alu_model(exe_cmd, a, b);
         exp_st = s; exp_dest = dest;
         exp_rd = mem_signal[1]; exp_wr = mem_signal[0]; exp_wb = wb_en;
      end
      @(posedge clk);
      #1;
      check_regs(tag);
      @(negedge clk);
   endtask

   logic [3:0] sweep_cmds [6];
   logic [31:0] sweep_exp [6];

   initial begin
      clear_inputs();
      rst = 0;
      exp_alu = 0; exp_st = 0; exp_dest = 0; exp_rd = 0; exp_wr = 0; exp_wb = 0;
      #3;
      check_regs("reset");
      check("reset.taken", {31'd0, branch_taken}, 32'd0);
      @(negedge clk);
      rst = 1;

      // Reset mid-operation
      exe_cmd = 4'd0; val1 = 5; val2 = 7; dest = 5'd3; wb_en = 1;
      step("add57");
      check("add57.const", alu_result_out, 32'd12);
      branch_type = 2'd3;
      #2 rst = 0;
      #1;
      exp_alu = 0; exp_st = 0; exp_dest = 0; exp_rd = 0; exp_wr = 0; exp_wb = 0;
      check_regs("arst");
      check("arst.taken", {31'd0, branch_taken}, 32'd0);
      @(negedge clk);
      rst = 1;
      clear_inputs();
      step("nop_after_rst");
      step("nop_after_rst2");

      // ALU sweep
      sweep_cmds = '{4'd0, 4'd2, 4'd9, 4'd10, 4'd8, 4'd15};
      sweep_exp  = '{32'hF000_0013, 32'hF000_000B, 32'hFF00_0000, 32'h0F00_0000,
                     32'h0000_00F0, 32'h0};
      for (int i = 0; i < 6; i++) begin
         val1 = 32'hF000_000F; val2 = 4; exe_cmd = sweep_cmds[i];
         step("sweep");
         check("sweep.const", alu_result_out, sweep_exp[i]);
      end
      // Shift by 32 behaves as shift by 0
      val1 = 32'h8000_0001; val2 = 32; exe_cmd = 4'd9;
      step("sra32");
      check("sra32.const", alu_result_out, 32'h8000_0001);

      // Forwarding
      clear_inputs();
      val1 = 1; val2 = 3; exe_cmd = 4'd0; mem_fwd_data = 100; wb_fwd_data = 200;
      fwd_sel1 = 2'd1;
      step("fwd_mem");
      check("fwd_mem.const", alu_result_out, 32'd103);
      fwd_sel1 = 2'd2;
      step("fwd_wb");
      check("fwd_wb.const", alu_result_out, 32'd203);
      fwd_sel1 = 2'd3;
      step("fwd_11");
      check("fwd_11.const", alu_result_out, 32'd4);
      fwd_sel_st = 2'd2; mem_signal = 2'b01; reg2 = 32'h55;
      step("fwd_st");
      check("fwd_st.const", st_value_out, 32'd200);
      check("fwd_st.wr", {31'd0, mem_write_out}, 32'd1);

      // Branches
      clear_inputs();
      pc = 32'h40; val2 = 3; branch_type = 2'd1; val1 = 0;
      #1;
      check("bez0.taken_c", {31'd0, branch_taken}, 32'd1);
      check("bez0.target_c", branch_target, 32'h4C);
      step("bez0");
      val1 = 1;             step("bez1");
      branch_type = 2'd2; val1 = 5; reg2 = 5; step("bne_eq");
      reg2 = 6;             step("bne_ne");
      branch_type = 2'd3;   step("jmp");
      val2 = 32'hFFFF_FFFF;
      #1;
      check("neg_off.target_c", branch_target, 32'h3C);
      step("neg_off");

      // Freeze
      clear_inputs();
      exe_cmd = 4'd0; val1 = 10; val2 = 5; dest = 5'd9; wb_en = 1;
      step("frz_add");
      freeze = 1; exe_cmd = 4'd2; val1 = 99; val2 = 1; dest = 5'd4; wb_en = 0; mem_signal = 2'b10;
      for (int i = 0; i < 3; i++) begin
         step("frz_hold");
         check("frz_hold.const", alu_result_out, 32'd15);
      end
      branch_type = 2'd3; pc = 32'h100; val2 = 1;
      step("frz_jmp");
      freeze = 0;
      #1;
      check("frz_jmp_rel.taken_c", {31'd0, branch_taken}, 32'd1);
      step("frz_jmp_rel");
      branch_type = 2'd0;
      step("frz_after");

      // Load path
      clear_inputs();
      exe_cmd = 4'd0; val1 = 32'h10; val2 = 8; mem_signal = 2'b10; wb_en = 1; dest = 5'd17;
      step("ld");
      check("ld.const", alu_result_out, 32'h18);
      check("ld.dest", {27'd0, dest_out}, 32'd17);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         freeze = ($urandom_range(0, 4) == 0);
         exe_cmd = 4'($urandom_range(0, 15));
         val1 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         val2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         reg2 = ($urandom_range(0, 2) == 0) ? val1 : $urandom;
         pc = $urandom;
         dest = 5'($urandom);
         mem_signal = 2'($urandom);
         branch_type = 2'($urandom);
         wb_en = 1'($urandom);
         fwd_sel1 = 2'($urandom);
         fwd_sel2 = 2'($urandom);
         fwd_sel_st = 2'($urandom);
         mem_fwd_data = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         wb_fwd_data = $urandom;
         step("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage pipeline: consumes the ID/EX register outputs (operands, PC, destination, control), resolves forwarding, computes the ALU result, and resolves branches. It holds the EX/MEM pipeline register that feeds the memory stage. Branch resolution drives the taken/target signals back to IF and the ID flush.

## Interface
Parameters: none (data width fixed at 32, register index at 5).

Ports:
- clk  in  1  pipeline clock, posedge active
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  memory-stage stall; holds the EX/MEM register
- val1  in  32  operand A from ID/EX
- val2  in  32  operand B from ID/EX (register or sign-extended immediate)
- reg2  in  32  rt register value (store data)
- pc  in  32  PC of the following instruction, from ID/EX
- dest  in  5  destination register index
- exe_cmd  in  4  ALU opcode
- mem_signal  in  2  [1]=read (LD), [0]=write (ST)
- branch_type  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP
- wb_en  in  1  write-back enable
- fwd_sel1 / fwd_sel2 / fwd_sel_st  in  2 each  forwarding selects for val1 / val2 / reg2: 00 ID/EX value, 01 mem_fwd_data, 10 wb_fwd_data, 11 ID/EX value
- mem_fwd_data  in  32  ALU result currently in MEM stage
- wb_fwd_data  in  32  data currently being written back
- branch_taken  out  1  combinational, to IF PC mux and ID flush
- branch_target  out  32  combinational target address
- alu_result_out  out  32  registered
- st_value_out  out  32  registered store data
- dest_out  out  5  registered
- mem_read_out, mem_write_out, wb_en_out  out  1 each  registered

## Operation
- Operands: a = fwd_sel1-mux(val1), b = fwd_sel2-mux(val2), s = fwd_sel_st-mux(reg2).
- ALU (exe_cmd): 0000 a+b; 0010 a-b; 0100 a&b; 0101 a|b; 0110 ~(a|b); 0111 a^b; 1000 a<<b[4:0]; 1001 a>>>b[4:0] (arithmetic); 1010 a>>b[4:0] (logical); any other code -> 0. All arithmetic modulo 2^32, no overflow flag.
- Branch condition: 01 BEZ taken iff a==0; 10 BNE taken iff a!=s; 11 JMP always; 00 never.
- branch_target = pc + (val2 << 2), 32-bit wrap-around; val2 not forwarded for target (always immediate).
- branch_taken = condition & ~freeze & rst (deasserted in reset).
- EX/MEM register, on posedge clk when freeze=0: alu_result_out<=ALU, st_value_out<=s, dest_out<=dest, mem_read_out<=mem_signal[1], mem_write_out<=mem_signal[0], wb_en_out<=wb_en. freeze=1: all hold.
- Branch instructions propagate into EX/MEM with wb_en/mem signals already 0 from decode; no internal squash.
- No internal FSM beyond the register; one instruction in flight.

## Timing
- Reset (rst=0, async, any time): every registered output -> 0 immediately; branch_taken=0. Released on first posedge after rst=1.
- Latency: inputs sampled at posedge N appear on registered outputs after posedge N; branch_taken/target valid in the same cycle the branch sits in ID/EX.
- freeze and branch simultaneously: branch_taken held 0 until freeze drops, then asserted for exactly one cycle (ID/EX must also be frozen upstream).
- Forwarding selects resolved combinationally in same cycle; 11 treated as 00.
- Shift amounts use only b[4:0]; b=32 shifts by 0.

## Test plan
- Reset mid-operation: load ADD 5+7, assert rst=0 between edges -> all outputs 0 asynchronously; after release, NOP inputs keep outputs 0.
- ALU sweep: a=0xF000_000F, b=4, each exe_cmd -> ADD 0xF000_0013, SUB 0xF000_000B, SRA 0xFF00_0000, SRL 0x0F00_0000, SLL 0x0000_00F0, code 1111 -> 0, one cycle later.
- Forwarding: val1=1, mem_fwd_data=100, wb_fwd_data=200, fwd_sel1=01 then 10, val2=3, ADD -> 103 then 203; fwd_sel_st=10 on ST -> st_value_out=200, mem_write_out=1.
- Branches: pc=0x40, val2=3; BEZ a=0 -> taken, target 0x4C; BEZ a=1 -> not taken; BNE a=5,s=5 -> not taken; JMP -> taken; val2=0xFFFF_FFFF -> target 0x3C.
- Freeze: ADD result latched, then freeze=1 with new SUB inputs for 3 cycles -> outputs unchanged; JMP during freeze -> branch_taken 0 until freeze=0, then 1 for one cycle.
- Load path: LD a=0x10, b=8 -> alu_result_out 0x18, mem_read_out=1, wb_en_out=1, dest_out passed through.
